// File: rtl/signed_2s_comp_add_if.sv
// rtl/signed_2s_comp_add_if.sv - operand/result bundle for the registered signed adder
interface signed_2s_comp_add_if;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] s_add;
  logic        overflow;
  logic        carry_out;
  logic        zero;
  logic        negative;

  modport master (
    output num1, num2,
    input  s_add, overflow, carry_out, zero, negative
  );

  modport slave (
    input  num1, num2,
    output s_add, overflow, carry_out, zero, negative
  );
endinterface

// File: rtl/signed_2s_comp_add.sv
// rtl/signed_2s_comp_add.sv - registered 32-bit two's-complement adder with status flags
// Two-level carry-lookahead: eight 4-bit CLA groups under a flat group-carry unit.
module signed_2s_comp_add (
  input  logic                      clk,
  input  logic                      rst,
  signed_2s_comp_add_if.slave       bus
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;
  logic [7:0]  w_gg;
  logic [7:0]  w_gp;
  logic [8:0]  w_cg;
  logic [31:0] w_sum;
  logic        w_ovf;

  logic [31:0] r_sum;
  logic        r_ovf;
  logic        r_cout;
  logic        r_zero;
  logic        r_neg;

  assign w_g = bus.num1 & bus.num2;
  assign w_p = bus.num1 ^ bus.num2;

  genvar j;
  generate
    for (j = 0; j < 8; j++) begin : g_cla
      logic [3:0] w_gl;
      logic [3:0] w_pl;
      logic       w_ci;
      assign w_gl = w_g[4*j +: 4];
      assign w_pl = w_p[4*j +: 4];
      assign w_ci = w_cg[j];

      assign w_c[4*j]   = w_ci;
      assign w_c[4*j+1] = w_gl[0] | (w_pl[0] & w_ci);
      assign w_c[4*j+2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_ci);
      assign w_c[4*j+3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                        | (w_pl[2] & w_pl[1] & w_pl[0] & w_ci);

      assign w_gg[j] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                     | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
      assign w_gp[j] = &w_pl;
    end
  endgenerate

  // Group carries as flat sum-of-products over group G/P (carry-in is 0), no group ripple.
  always_comb begin
    logic w_acc;
    logic w_term;
    w_cg    = '0;
    w_acc   = 1'b0;
    w_term  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      w_acc = 1'b0;
      for (int s = 0; s < k; s++) begin
        w_term = w_gg[s];
        for (int m = s + 1; m < k; m++) begin
          w_term = w_term & w_gp[m];
        end
        w_acc = w_acc | w_term;
      end
      w_cg[k] = w_acc;
    end
  end

  assign w_c[32] = w_cg[8];
  assign w_sum   = w_p ^ w_c[31:0];
  assign w_ovf   = w_c[32] ^ w_c[31];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= 32'h0000_0000;
      r_ovf  <= 1'b0;
      r_cout <= 1'b0;
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_ovf  <= w_ovf;
      r_cout <= w_c[32];
      r_zero <= ~|w_sum;
      r_neg  <= w_sum[31];
    end
  end

  assign bus.s_add     = r_sum;
  assign bus.overflow  = r_ovf;
  assign bus.carry_out = r_cout;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_neg;

endmodule

// File: tb/tb_signed_2s_comp_add.sv
// tb/tb_signed_2s_comp_add.sv - vector table, corner sequences and random run against an arithmetic model
module tb_signed_2s_comp_add;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  signed_2s_comp_add_if bus ();

  signed_2s_comp_add dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        ovf;
    logic        cout;
    logic        zero;
    logic        neg;
  } vec_t;

  vec_t vecs [10];

  // Result and flags from plain wide-integer arithmetic: {sum, ovf, cout, zero, neg}.
  function automatic logic [35:0] model(input logic r, input logic [31:0] a, input logic [31:0] b);
    longint ss;
    longint us;
    logic [31:0] s;
    logic ov;
    if (r) return {32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    ss = longint'($signed(a)) + longint'($signed(b));
    us = longint'(a) + longint'(b);
    s  = us[31:0];
    ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {s, ov, us[32], (s == 32'h0), s[31]};
  endfunction

  task automatic check(input string nm, input logic [35:0] exp);
    logic [35:0] got;
    got = {bus.s_add, bus.overflow, bus.carry_out, bus.zero, bus.negative};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got sum=%h ovf=%b cout=%b zero=%b neg=%b, expected sum=%h ovf=%b cout=%b zero=%b neg=%b",
                  nm, got[35:4], got[3], got[2], got[1], got[0],
                  exp[35:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b);
    rst      = r;
    bus.num1 = a;
    bus.num2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [35:0] held;
    logic        rr;
    logic [31:0] ra;
    logic [31:0] rb;
    n_total = 0;
    n_pass  = 0;
    rst      = 1'b1;
    bus.num1 = 32'd0;
    bus.num2 = 32'd0;

    vecs[0] = '{1'b1, 32'd10, 32'd3, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'd10, 32'd3, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'd10, 32'd3, 32'h0000_000D, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'hFFFF_FFF1, 32'd21, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 32'd5, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].rst, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i),
            {vecs[i].sum, vecs[i].ovf, vecs[i].cout, vecs[i].zero, vecs[i].neg});
    end

    // Mid-stream reset discards the in-flight pair; the first pair after release lands at once.
    apply(1'b0, 32'd1, 32'd2);
    check("pre_reset", {32'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    apply(1'b1, 32'd7, 32'd7);
    check("mid_reset", {32'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    apply(1'b0, 32'd4, 32'd4);
    check("post_reset", {32'd8, 1'b0, 1'b0, 1'b0, 1'b0});

    // Operand changes between edges must not reach the outputs.
    held = {32'd8, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.num1 = 32'hFFFF_FFFF;
    bus.num2 = 32'hFFFF_FFFF;
    #3;
    check("hold_between_edges", held);

    for (int i = 0; i < 10000; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = -ra; end
        1: begin ra = {1'b0, 31'($urandom)}; rb = {1'b0, 31'($urandom)}; end
        2: begin ra = {1'b1, 31'($urandom)}; rb = {1'b1, 31'($urandom)}; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      apply(rr, ra, rb);
      check($sformatf("rand%0d", i), model(rr, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/signed_2s_comp_add.md
# signed_2s_comp_add

Registered 32-bit two's-complement signed adder with arithmetic status flags. It sums two signed operands and presents the wrapped 32-bit result plus overflow, carry, zero and negative flags one clock after the operands are sampled. It serves as the integer add datapath element in the combinational/arithmetic unit collection, with its output registered so it can sit directly in a pipelined datapath.

## Interface
- No parameters; width fixed at 32 bits.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset; sampled on rising edge of `clk`.
- `num1`  input  32  signed two's-complement operand A.
- `num2`  input  32  signed two's-complement operand B.
- `s_add`  output  32  registered signed sum `num1 + num2`, modulo 2^32.
- `overflow`  output  1  registered signed-overflow flag for the sum.
- `carry_out`  output  1  registered carry out of bit 31 (unsigned carry).
- `zero`  output  1  registered flag, 1 when `s_add` is all zeros.
- `negative`  output  1  registered flag, equal to bit 31 of `s_add`.

## Operation
- Adder core is structural carry-lookahead: eight 4-bit CLA groups (per-bit generate `g = a&b`, propagate `p = a^b`, group G/P, group carries), chained through a second-level lookahead unit over the eight groups; carry-in is 0.
- Sum bit i = `p[i] ^ c[i]`; `carry_out` = c[32].
- `overflow` = `(num1[31] == num2[31]) && (sum[31] != num1[31])`; equivalently c[32] ^ c[31]. Both forms must agree.
- Result wraps modulo 2^32 on overflow; no saturation.
- `negative` = sum[31] regardless of overflow.
- `zero` = NOR of all 32 sum bits.
- All five outputs come from registers loaded together; the combinational sum never drives ports directly.
- No handshake: a new operand pair is accepted every cycle.

## Timing
- Latency 1 cycle: operands present at rising edge N appear on outputs after edge N, held until edge N+1.
- Throughput 1 result per cycle.
- Reset (`rst`=1 at a rising edge): `s_add` = 0x00000000, `overflow` = 0, `carry_out` = 0, `negative` = 0, `zero` = 1 (consistent with a zero result). Reset overrides the operands sampled at that edge.
- Reset deasserted at edge N: outputs after edge N reflect operands at edge N; no extra warm-up cycle.
- Reset asserted mid-stream: the in-flight result is discarded; outputs show reset values after that edge.
- Operand changes between edges have no effect on outputs. The adder path must close timing in one cycle.

## Test plan
- Reset: hold `rst`=1 for 2 edges with `num1`=10, `num2`=3 -> `s_add`=0, `zero`=1, all other flags 0; release -> next edge `s_add`=13 (0x0000000D), all flags 0.
- Mixed signs and negatives, one pair per cycle: (10,3) -> 13. (-5,-3) -> 0xFFFFFFF8 (-8), `negative`=1, `carry_out`=1, `overflow`=0. (2,-7) -> 0xFFFFFFFB (-5), `negative`=1, `carry_out`=0. (-15,21) -> 6, `carry_out`=1, `negative`=0. Each result appears exactly one cycle after its operands.
- Positive overflow: 0x7FFFFFFF + 0x00000001 -> `s_add`=0x80000000, `overflow`=1, `negative`=1, `carry_out`=0.
- Negative overflow / zero wrap: 0x80000000 + 0x80000000 -> `s_add`=0, `overflow`=1, `carry_out`=1, `zero`=1, `negative`=0.
- Full carry chain: 0xFFFFFFFF + 0x00000001 -> `s_add`=0, `zero`=1, `carry_out`=1, `overflow`=0. Also 5 + (-5) -> 0, `zero`=1, `carry_out`=1.
- Random: ≥10,000 random pairs, with mid-stream resets, checked against a reference model of a 33-bit sum at 1-cycle latency, including all four flags.
